// File: rtl/conversor_temp.sv
// conversor_temp: sequential Celsius-to-Fahrenheit converter.
// Computes F = floor(C*9/5) + OFFSET using a shift-add multiply followed by a
// bit-serial restoring divide by 5. The result saturates to 2^W-1.
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   conversion request, sampled only while idle
//   numeroC_in  in   W-bit unsigned Celsius sample, captured on the accepting edge
//   numeroC     out  registered Celsius value of the last completed conversion
//   numeroF     out  registered Fahrenheit value of the last completed conversion (saturated)
//   busy        out  high while a conversion is in flight
//   done        out  one-cycle pulse when numeroC/numeroF update
//   sat         out  1 if the last numeroF was clamped
module conversor_temp #(
   parameter int unsigned W      = 10,
   parameter int unsigned OFFSET = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] numeroC_in,
   output logic [W-1:0] numeroC,
   output logic [W-1:0] numeroF,
   output logic         busy,
   output logic         done,
   output logic         sat
);

   localparam int unsigned CntW = $clog2(W + 4);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StAdd} state_e;

   state_e          state_q;
   logic [W-1:0]    c_q;
   logic [W+3:0]    prod_q;
   logic [W+3:0]    quo_q;
   logic [2:0]      rem_q;    // remainder is always < 5 between steps
   logic [CntW-1:0] cnt_q;

   logic [3:0]      rem_shift;
   logic            rem_ge;
   logic [2:0]      rem_next;
   logic [W+4:0]    f_sum;
   logic            f_ovf;

   // One restoring-division step and the final offset/saturation check.
   always_comb begin
      rem_shift = {rem_q, prod_q[cnt_q]};
      rem_ge    = (rem_shift >= 4'd5);
      rem_next  = rem_ge ? 3'(rem_shift - 4'd5) : rem_shift[2:0];
      f_sum     = {1'b0, quo_q} + (W + 5)'(OFFSET);
      f_ovf     = |f_sum[W+4:W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         c_q     <= '0;
         prod_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         numeroC <= '0;
         numeroF <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sat     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  c_q     <= numeroC_in;
                  busy    <= 1'b1;
                  state_q <= StMul;
               end
            end
            StMul: begin
               // c*9 = (c << 3) + c
               prod_q  <= {1'b0, c_q, 3'b000} + {4'b0000, c_q};
               quo_q   <= '0;
               rem_q   <= '0;
               cnt_q   <= CntW'(W + 3);
               state_q <= StDiv;
            end
            StDiv: begin
               rem_q        <= rem_next;
               quo_q[cnt_q] <= rem_ge;
               if (cnt_q == '0) begin
                  state_q <= StAdd;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StAdd: begin
               numeroC <= c_q;
               numeroF <= f_ovf ? '1 : f_sum[W-1:0];
               sat     <= f_ovf;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_conversor_temp.sv
// Testbench for conversor_temp: randomized and directed requests, a
// behavioural reference model and a scoreboard checked by a separate monitor.
module tb_conversor_temp;

   localparam int W    = 10;
   localparam int FMAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] numeroC_in = '0;
   logic [W-1:0] numeroC;
   logic [W-1:0] numeroF;
   logic         busy;
   logic         done;
   logic         sat;

   conversor_temp #(.W(W), .OFFSET(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .numeroC_in (numeroC_in),
      .numeroC    (numeroC),
      .numeroF    (numeroF),
      .busy       (busy),
      .done       (done),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   // cyc holds the index of the most recent rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int f;
      int s;
      int done_at;
   } exp_t;

   exp_t sb[$];
   int   last_acc = -1000;
   int   checks   = 0;
   int   failures = 0;

   function automatic void model(input int c, output int f, output int s);
      int raw;
      raw = (c * 9) / 5 + 32;
      s   = (raw > FMAX) ? 1 : 0;
      f   = (raw > FMAX) ? FMAX : raw;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of stimulus; the model accepts a request only when the
   // previous conversion has fully retired (17-cycle period).
   task automatic step(input bit st, input int c);
      int f;
      int s;
      int e;
      @(negedge clk);
      start      = st;
      numeroC_in = c[W-1:0];
      e          = cyc + 1;
      if (rst_n && st && (e >= last_acc + 17)) begin
         model(c, f, s);
         sb.push_back('{c: c, f: f, s: s, done_at: e + 16});
         last_acc = e;
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, int'($urandom_range(0, FMAX)));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_numeroC"}, int'(numeroC), 0);
      check({tag, "_numeroF"}, int'(numeroF), 0);
      check({tag, "_busy"},    int'(busy),    0);
      check({tag, "_done"},    int'(done),    0);
      check({tag, "_sat"},     int'(sat),     0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n    = 1'b0;
      start    = 1'b0;
      sb.delete();
      last_acc = -1000;
      #1;
      check_zero("async_reset");
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: busy every cycle, results whenever done is presented.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         check("busy", int'(busy), (cyc >= last_acc && cyc < last_acc + 16) ? 1 : 0);
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("latency", cyc, e.done_at);
               check("numeroC", int'(numeroC), e.c);
               check("numeroF", int'(numeroF), e.f);
               check("sat",     int'(sat),     e.s);
            end
         end else if (sb.size() > 0 && sb[0].done_at < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_done actual=0 expected=1 (due cycle %0d)", sb[0].done_at);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      int dc[6];
      dc = '{0, 100, 37, 551, 552, 1023};

      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Directed values including the saturation boundary.
      foreach (dc[i]) begin
         step(1'b1, dc[i]);
         idle(17);
      end

      // Second request while busy is dropped.
      step(1'b1, 100);
      idle(4);
      step(1'b1, 0);
      idle(20);

      // start held high: a conversion every 17 cycles.
      repeat (17 * 4) step(1'b1, 20);
      idle(20);

      // Reset mid-conversion, then a normal conversion.
      step(1'b1, 100);
      idle(20);
      step(1'b1, 37);
      idle(7);
      do_reset(2);
      step(1'b1, 37);
      idle(20);

      // Random traffic, biased partly toward the saturation boundary.
      repeat (400) begin
         int c;
         c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(540, 560))
                                         : int'($urandom_range(0, FMAX));
         step($urandom_range(0, 3) == 0, c);
      end
      idle(20);

      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
